// File: rtl/if_id_decode_if.sv
// Fetch-to-decode bundle: fetch/hazard inputs into the IF/ID register and the
// decoded instruction fields and controls coming back out.
interface if_id_decode_if #(
  parameter int PC_WIDTH = 32
);
  logic                in_valid;
  logic [31:0]         in_instr;
  logic [PC_WIDTH-1:0] in_pc;
  logic                stall;
  logic                flush;
  logic                in_ready;
  logic                out_valid;
  logic [31:0]         out_instr;
  logic [PC_WIDTH-1:0] out_pc;
  logic [5:0]          opcode;
  logic [5:0]          funct;
  logic [4:0]          rs;
  logic [4:0]          rt;
  logic [4:0]          rd;
  logic [4:0]          shamt;
  logic [15:0]         imm;
  logic                sign_ext;
  logic                reg_write;
  logic                reg_dst;
  logic                alu_src;
  logic                mem_read;
  logic                mem_write;
  logic                branch;
  logic                jump;
  logic                illegal;

  modport master (
    output in_valid, in_instr, in_pc, stall, flush,
    input  in_ready, out_valid, out_instr, out_pc, opcode, funct, rs, rt, rd,
           shamt, imm, sign_ext, reg_write, reg_dst, alu_src, mem_read,
           mem_write, branch, jump, illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, stall, flush,
    output in_ready, out_valid, out_instr, out_pc, opcode, funct, rs, rt, rd,
           shamt, imm, sign_ext, reg_write, reg_dst, alu_src, mem_read,
           mem_write, branch, jump, illegal
  );
endinterface

// File: rtl/if_id_decode.sv
// IF/ID pipeline register with flush/stall priority and combinational MIPS-style
// field slicing and control decode from the registered instruction word.
module if_id_decode #(
  parameter int          PC_WIDTH  = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  if_id_decode_if.slave bus
);

  typedef struct packed {
    logic sign_ext;
    logic reg_write;
    logic reg_dst;
    logic alu_src;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
    logic illegal;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      6'h00: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      6'h08, 6'h09, 6'h0A, 6'h0B: begin
        c.reg_write = 1'b1; c.alu_src = 1'b1; c.sign_ext = 1'b1;
      end
      6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        c.reg_write = 1'b1; c.alu_src = 1'b1;
      end
      6'h23: begin
        c.reg_write = 1'b1; c.alu_src = 1'b1; c.mem_read = 1'b1; c.sign_ext = 1'b1;
      end
      6'h2B: begin c.alu_src = 1'b1; c.mem_write = 1'b1; c.sign_ext = 1'b1; end
      6'h04, 6'h05: begin c.branch = 1'b1; c.sign_ext = 1'b1; end
      6'h02: c.jump = 1'b1;
      6'h03: begin c.jump = 1'b1; c.reg_write = 1'b1; end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  logic                vld_p1;
  logic [31:0]         instr_p1;
  logic [PC_WIDTH-1:0] pc_p1;
  ctrl_t               ctrl;

  assign bus.in_ready = !bus.stall;

  // Stage p0 -> p1: flush beats stall beats load; a bubble keeps the old pc
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      instr_p1 <= NOP_INSTR;
      pc_p1    <= '0;
    end else if (bus.flush) begin
      vld_p1   <= 1'b0;
      instr_p1 <= NOP_INSTR;
      pc_p1    <= '0;
    end else if (!bus.stall) begin
      if (bus.in_valid) begin
        vld_p1   <= 1'b1;
        instr_p1 <= bus.in_instr;
        pc_p1    <= bus.in_pc;
      end else begin
        vld_p1   <= 1'b0;
        instr_p1 <= NOP_INSTR;
      end
    end
  end

  // Stage p1 decode: controls are forced low whenever the slot is empty
  always_comb begin
    ctrl = '0;
    if (vld_p1) ctrl = decode_ctrl(instr_p1[31:26]);
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_instr = instr_p1;
  assign bus.out_pc    = pc_p1;
  assign bus.opcode    = instr_p1[31:26];
  assign bus.rs        = instr_p1[25:21];
  assign bus.rt        = instr_p1[20:16];
  assign bus.rd        = instr_p1[15:11];
  assign bus.shamt     = instr_p1[10:6];
  assign bus.funct     = instr_p1[5:0];
  assign bus.imm       = instr_p1[15:0];
  assign bus.sign_ext  = ctrl.sign_ext;
  assign bus.reg_write = ctrl.reg_write;
  assign bus.reg_dst   = ctrl.reg_dst;
  assign bus.alu_src   = ctrl.alu_src;
  assign bus.mem_read  = ctrl.mem_read;
  assign bus.mem_write = ctrl.mem_write;
  assign bus.branch    = ctrl.branch;
  assign bus.jump      = ctrl.jump;
  assign bus.illegal   = ctrl.illegal;

endmodule

// File: tb/tb_if_id_decode.sv
// Bench for if_id_decode: directed instruction cases plus randomized traffic
// compared every cycle against a behavioural model of the decode register.
module tb_if_id_decode;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  if_id_decode_if #(.PC_WIDTH(32)) bus ();

  if_id_decode #(.PC_WIDTH(32), .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model state: what the decode slot must hold
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = NOP;
  logic [31:0] m_pc = 32'h0;
  bit          m_pc_known = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_instr <= NOP; m_pc <= 32'h0; m_pc_known <= 1'b1;
    end else if (bus.flush) begin
      m_valid <= 1'b0; m_instr <= NOP; m_pc <= 32'h0; m_pc_known <= 1'b1;
    end else if (bus.stall) begin
      m_valid <= m_valid;
    end else if (bus.in_valid) begin
      m_valid <= 1'b1; m_instr <= bus.in_instr; m_pc <= bus.in_pc; m_pc_known <= 1'b1;
    end else begin
      m_valid <= 1'b0; m_instr <= NOP; m_pc_known <= 1'b0;
    end
  end

  // {sign_ext, reg_write, reg_dst, alu_src, mem_read, mem_write, branch, jump, illegal}
  function automatic logic [8:0] exp_ctl(input logic [5:0] op, input logic v);
    logic sx, rw, rdst, alu, mr, mw, br, j, legal;
    legal = op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, [6'h08:6'h0F], 6'h23, 6'h2B};
    rw    = op inside {6'h00, [6'h08:6'h0F], 6'h23, 6'h03};
    rdst  = (op == 6'h00);
    alu   = op inside {[6'h08:6'h0F], 6'h23, 6'h2B};
    sx    = op inside {[6'h08:6'h0B], 6'h23, 6'h2B, 6'h04, 6'h05};
    mr    = (op == 6'h23);
    mw    = (op == 6'h2B);
    br    = op inside {6'h04, 6'h05};
    j     = op inside {6'h02, 6'h03};
    if (!v) return 9'b0;
    return {sx, rw, rdst, alu, mr, mw, br, j, !legal};
  endfunction

  function automatic logic [8:0] dut_ctl();
    return {bus.sign_ext, bus.reg_write, bus.reg_dst, bus.alu_src, bus.mem_read,
            bus.mem_write, bus.branch, bus.jump, bus.illegal};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", bus.in_ready, !bus.stall);
      chk("out_valid", bus.out_valid, m_valid);
      chk("out_instr", bus.out_instr, m_instr);
      chk("fields", {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct}, m_instr);
      chk("imm", bus.imm, m_instr[15:0]);
      chk("controls", dut_ctl(), exp_ctl(m_instr[31:26], m_valid));
      if (m_pc_known) chk("out_pc", bus.out_pc, m_pc);
    end
  end

  // Drive inputs, then step past one rising edge
  task automatic apply(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic st, input logic fl);
    bus.in_valid = v; bus.in_instr = instr; bus.in_pc = pc;
    bus.stall = st; bus.flush = fl;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0]  op;
    w = $urandom();
    case ($urandom_range(0, 15))
      0: op = 6'h00;  1: op = 6'h08;  2: op = 6'h0B;  3: op = 6'h0C;
      4: op = 6'h0E;  5: op = 6'h0F;  6: op = 6'h23;  7: op = 6'h2B;
      8: op = 6'h04;  9: op = 6'h05; 10: op = 6'h02; 11: op = 6'h03;
      12: op = 6'h09; 13: op = 6'h0D; 14: op = 6'h0A;
      default: op = 6'($urandom());
    endcase
    w[31:26] = op;
    return w;
  endfunction

  initial begin
    bus.in_valid = 1'b0; bus.in_instr = 32'h0; bus.in_pc = 32'h0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_instr", bus.out_instr, NOP);
    chk("rst_pc", bus.out_pc, 32'h0);
    chk("rst_ctl", dut_ctl(), 9'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // addi $t0, $zero, -1
    apply(1'b1, 32'h2008FFFF, 32'h40, 1'b0, 1'b0);
    chk("addi_valid", bus.out_valid, 1'b1);
    chk("addi_opcode", bus.opcode, 6'h08);
    chk("addi_rt", bus.rt, 5'd8);
    chk("addi_imm", bus.imm, 16'hFFFF);
    chk("addi_ctl", dut_ctl(), 9'b1_1_0_1_0_0_0_0_0);
    chk("addi_pc", bus.out_pc, 32'h40);

    apply(1'b1, 32'h3108FFFF, 32'h44, 1'b0, 1'b0);
    chk("andi_ctl", dut_ctl(), 9'b0_1_0_1_0_0_0_0_0);
    chk("andi_imm", bus.imm, 16'hFFFF);
    apply(1'b1, 32'h8D090004, 32'h48, 1'b0, 1'b0);
    chk("lw_ctl", dut_ctl(), 9'b1_1_0_1_1_0_0_0_0);
    chk("lw_rt", bus.rt, 5'd9);

    // add held across a 3-cycle stall while fetch keeps changing
    apply(1'b1, 32'h012A4020, 32'h4C, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 32'h2008_0000 + 32'(i), 32'h50 + 32'(4 * i), 1'b1, 1'b0);
      chk("stall_instr", bus.out_instr, 32'h012A4020);
      chk("stall_ready", bus.in_ready, 1'b0);
      chk("stall_pc", bus.out_pc, 32'h4C);
      chk("stall_ctl", dut_ctl(), 9'b0_1_1_0_0_0_0_0_0);
    end
    apply(1'b1, 32'h8D090004, 32'h60, 1'b0, 1'b0);
    chk("post_stall_instr", bus.out_instr, 32'h8D090004);
    chk("post_stall_pc", bus.out_pc, 32'h60);

    // flush beats stall
    apply(1'b1, 32'h2008FFFF, 32'h64, 1'b1, 1'b1);
    chk("flush_valid", bus.out_valid, 1'b0);
    chk("flush_instr", bus.out_instr, NOP);
    chk("flush_pc", bus.out_pc, 32'h0);
    chk("flush_ctl", dut_ctl(), 9'b0);

    apply(1'b1, 32'hFC000000, 32'h68, 1'b0, 1'b0);
    chk("illegal_ctl", dut_ctl(), 9'b0_0_0_0_0_0_0_0_1);

    apply(1'b0, 32'h2008FFFF, 32'h6C, 1'b0, 1'b0);
    chk("bubble_valid", bus.out_valid, 1'b0);
    chk("bubble_instr", bus.out_instr, NOP);

    // asynchronous reset while holding a live instruction
    apply(1'b1, 32'h012A4020, 32'h70, 1'b0, 1'b0);
    bus.in_instr = 32'h10000003; bus.in_pc = 32'h80;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 1'b0);
    chk("arst_instr", bus.out_instr, NOP);
    chk("arst_pc", bus.out_pc, 32'h0);
    chk("arst_ctl", dut_ctl(), 9'b0);
    @(posedge clk); #3 rst_n = 1'b1;
    #1 chk("arst_release_valid", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    chk("beq_valid", bus.out_valid, 1'b1);
    chk("beq_ctl", dut_ctl(), 9'b1_0_0_0_0_0_1_0_0);
    chk("beq_imm", bus.imm, 16'h0003);
    chk("beq_pc", bus.out_pc, 32'h80);

    // randomized traffic, checked by the per-cycle compare process
    for (int i = 0; i < 600; i++) begin
      apply($urandom_range(0, 3) != 0, rand_instr(), $urandom(),
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
    end

    apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
